// File: rtl/mem_fill_arbiter.sv
// Miss arbiter between the I/D caches and the unified memory port: one line
// transaction at a time, optional dirty-victim writeback before each D fill.
module mem_fill_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [13:0] i_blk_addr,
    input  logic        d_req,
    input  logic [13:0] d_blk_addr,
    input  logic        d_victim_dirty,
    input  logic [7:0]  d_victim_tag,
    input  logic [63:0] d_victim_data,
    input  logic        m_rdy,
    input  logic [63:0] m_rd_data,
    output logic [13:0] m_addr,
    output logic        m_re,
    output logic        m_we,
    output logic [63:0] m_wdata,
    output logic        i_fill_we,
    output logic [63:0] i_fill_data,
    output logic        d_fill_we,
    output logic [63:0] d_fill_data,
    output logic        d_fill_dirty,
    output logic        i_ack,
    output logic        d_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t      state;
    logic        owner;
    logic        prio;
    logic        cooldown;
    logic [13:0] blk_addr;
    logic [63:0] fill_line;

    logic        grant_valid;
    logic        grant_d;
    logic [13:0] grant_addr;

    // The cycle right after DONE ignores requests so the acked side can drop its req.
    always_comb begin
        grant_valid = (i_req || d_req) && !cooldown;
        grant_d     = d_req && (!i_req || (prio == SIDE_D));
        grant_addr  = grant_d ? d_blk_addr : i_blk_addr;
    end

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= SIDE_I;
            prio      <= SIDE_D;
            cooldown  <= 1'b0;
            blk_addr  <= '0;
            fill_line <= '0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_re      <= 1'b0;
            m_we      <= 1'b0;
            i_fill_we <= 1'b0;
            d_fill_we <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            i_fill_we <= 1'b0;
            d_fill_we <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            cooldown  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner    <= grant_d;
                        blk_addr <= grant_addr;
                        busy     <= 1'b1;
                        if (i_req && d_req) begin
                            prio <= ~prio;
                        end
                        if (grant_d && d_victim_dirty) begin
                            state   <= WB;
                            m_we    <= 1'b1;
                            m_addr  <= {d_victim_tag, d_blk_addr[5:0]};
                            m_wdata <= d_victim_data;
                        end else begin
                            state  <= FILL;
                            m_re   <= 1'b1;
                            m_addr <= grant_addr;
                        end
                    end
                end
                WB: begin
                    if (m_rdy) begin
                        state  <= FILL;
                        m_we   <= 1'b0;
                        m_re   <= 1'b1;
                        m_addr <= blk_addr;
                    end
                end
                FILL: begin
                    if (m_rdy) begin
                        state     <= DONE;
                        m_re      <= 1'b0;
                        fill_line <= m_rd_data;
                        if (owner == SIDE_D) begin
                            d_fill_we <= 1'b1;
                            d_ack     <= 1'b1;
                        end else begin
                            i_fill_we <= 1'b1;
                            i_ack     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cooldown <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i_fill_data  = fill_line;
    assign d_fill_data  = fill_line;
    assign d_fill_dirty = 1'b0;

endmodule

// File: doc/mem_fill_arbiter.md
# mem_fill_arbiter

Arbitrates cache miss traffic from the I-cache and D-cache onto the single unified main memory port, and sequences each D-side miss as an optional dirty-victim writeback followed by a line fill. It sits between the two `cache` instances, `cache_control` and `unified_mem` in `system_memory`. It serves one 64-bit line transaction at a time, alternates priority when both sides miss together, and returns filled lines to the requesting cache with a single-cycle write strobe.

## Interface
- No parameters. Fixed geometry: 14-bit block address = {tag[7:0], index[5:0]}; 64-bit line.
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- i_req  in  1  I-cache miss request; held high until i_ack
- i_blk_addr  in  14  I-side missing block address (i_addr[15:2])
- d_req  in  1  D-cache miss request; held high until d_ack
- d_blk_addr  in  14  D-side missing block address (d_addr[15:2])
- d_victim_dirty  in  1  the resident D line at this index is dirty
- d_victim_tag  in  8  tag of the resident D line
- d_victim_data  in  64  data of the resident D line
- m_rdy  in  1  memory completion pulse, one cycle
- m_rd_data  in  64  memory read data, valid when m_rdy=1 during a read
- m_addr  out  14  memory block address
- m_re  out  1  memory read request
- m_we  out  1  memory write request
- m_wdata  out  64  memory write data
- i_fill_we  out  1  write strobe to the I-cache
- i_fill_data  out  64  line written to the I-cache
- d_fill_we  out  1  write strobe to the D-cache
- d_fill_data  out  64  line written to the D-cache
- d_fill_dirty  out  1  dirty bit written with the fill; always 0
- i_ack  out  1  one-cycle completion pulse to the I side
- d_ack  out  1  one-cycle completion pulse to the D side
- busy  out  1  high whenever state is not IDLE

## Operation
- All outputs are registered. States are IDLE, WB, FILL and DONE. A 1-bit `owner` register records the side being served (0 = I, 1 = D). A 1-bit `prio` register records which side wins a tie.
- IDLE:
  - If only one of i_req or d_req is high, that side is granted.
  - If both are high, the side named by `prio` is granted, and `prio` then flips to the other side.
  - On grant, the block address and owner are latched. For a D grant, the victim dirty bit, tag and data are also latched.
- Next state after grant:
  - D grant with victim dirty: go to WB.
  - Otherwise: go to FILL.
- WB:
  - Drive m_we=1, m_addr={victim_tag, blk_addr[5:0]} and m_wdata=victim_data.
  - On m_rdy, go to FILL. m_we falls and m_re rises on the same edge, so there is no gap cycle.
- FILL:
  - Drive m_re=1 and m_addr=latched blk_addr.
  - On m_rdy, capture m_rd_data into the fill register and go to DONE.
- DONE (exactly one cycle):
  - Owner I: i_fill_we=1 and i_ack=1. Owner D: d_fill_we=1, d_fill_dirty=0 and d_ack=1.
  - fill_data equals the captured line.
  - Next state is IDLE.
- In IDLE, any request seen in the cycle directly after DONE is ignored. This gives the acked requester time to drop its req.
- m_re and m_we are never high together. Address and data stay stable while m_re or m_we is high.
- Requests and inputs are ignored outside IDLE. A req that falls mid-transaction does not abort it; the transaction completes and the ack is still issued.
- m_rdy is ignored in IDLE and in DONE.
- Reset (asynchronous, any state):
  - State goes to IDLE, with m_re=0, m_we=0, all strobes and acks 0, busy=0.
  - m_addr, m_wdata and fill data go to 0.
  - `prio` resets to D (D wins the first tie).
  - An in-flight transaction is abandoned with no ack.

## Timing
- Cycle 0: req sampled in IDLE.
- Cycle 1: m_re (clean miss) or m_we (dirty D miss) is high. Memory may assert m_rdy in any cycle the request is high, including the first.
- Clean miss with m_rdy at cycle t: DONE and ack at t+1, IDLE at t+2. Minimum ack is cycle 2.
- Dirty miss with WB m_rdy at t1 and FILL m_rdy at t2: FILL starts at t1+1 and ack is at t2+1. Minimum ack is cycle 3.
- Back-to-back transactions: the earliest next grant is sampled at DONE+2. m_re or m_we rises again at DONE+3.
- Throughput: one line transaction in flight. Memory latency is unbounded, and the block waits indefinitely for m_rdy.

## Test plan
- Reset mid-FILL: i_req with m_rdy withheld, rst_n pulsed low → m_re drops immediately, no i_ack. After release, busy=0 and m_re=0.
- Clean I miss: i_req with i_blk_addr=14'h0A5 and m_rdy at the first m_re cycle, m_rd_data=64'h0123_4567_89AB_CDEF → m_addr=14'h0A5, m_re high 1 cycle, i_fill_we and i_ack at cycle 2, i_fill_data=64'h0123_4567_89AB_CDEF.
- Dirty D miss: d_blk_addr=14'h3C7, victim_tag=8'h12, victim_data=64'hDEAD_BEEF_0000_1111, memory latency 3 cycles each → WB phase shows m_we with m_addr=14'h487 and m_wdata=the victim data. FILL phase shows m_re with m_addr=14'h3C7. d_fill_we=1, d_fill_dirty=0 and d_ack=1 in the same cycle, with m_re and m_we never high together.
- Simultaneous i_req and d_req out of reset, both held and re-raised for a second round → D is served first, then I. On the next tie, I is served first.
- Latency sweep: m_rdy delayed 0..10 cycles → m_addr and m_wdata remain stable until m_rdy, there is exactly one ack per request, and a spurious m_rdy in IDLE produces no strobe.
